// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the memory-stage data bus between the CPU (priority) and a single-beat
// secondary master, forcing a one-cycle CPU stall when the secondary master has waited too long.
module dbus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_we,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_we,
   output logic        dma_gnt,
   output logic        dma_done,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);
   logic [CNT_W-1:0] wait_q, wait_d;
   logic             done_q;
   logic [31:0]      rdata_q, rdata_d;
   logic             frc;
   always_comb begin
      frc       = dma_req & cpu_req & (wait_q == CNT_W'(STARVE_LIMIT));
      dma_gnt   = dma_req & (~cpu_req | frc);
      cpu_stall = frc;
      mem_addr  = dma_gnt ? dma_addr : cpu_addr;
      mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
      mem_we    = dma_gnt ? dma_we : (cpu_we & cpu_req);
      // saturating count of consecutive denied cycles; a grant or a dropped request clears it
      wait_d    = (dma_gnt | ~dma_req) ? '0
                : (wait_q == CNT_W'(STARVE_LIMIT)) ? wait_q : wait_q + 1'b1;
      rdata_d   = dma_gnt ? mem_rdata : rdata_q;
   end
   assign cpu_rdata = mem_rdata;
   assign dma_done  = done_q;
   assign dma_rdata = rdata_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_q  <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         wait_q  <= wait_d;
         done_q  <= dma_gnt;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed vector table, async-reset sequence and constrained-random traffic
// checked against a cycle-level behavioural model of the arbiter.
module tb_dbus_arbiter;
   localparam int LIM = 4;

   logic        clk = 1'b0, reset = 1'b0;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
   logic        cpu_stall, dma_gnt, dma_done, mem_we;

   dbus_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // behavioural model: number of consecutive cycles the secondary master was refused
   int          denied = 0;
   logic        m_done = 1'b0, m_frc, m_gnt;
   logic [31:0] m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      m_frc = dma_req && cpu_req && denied == LIM;
      m_gnt = dma_req && (!cpu_req || m_frc);
   endtask

   task automatic model_check();
      model_eval();
      chk("gnt", {31'b0, dma_gnt}, {31'b0, m_gnt});
      chk("stall", {31'b0, cpu_stall}, {31'b0, m_frc});
      chk("mem_addr", mem_addr, m_gnt ? dma_addr : cpu_addr);
      chk("mem_wdata", mem_wdata, m_gnt ? dma_wdata : cpu_wdata);
      chk("mem_we", {31'b0, mem_we}, {31'b0, m_gnt ? dma_we : (cpu_req && cpu_we)});
      chk("cpu_rdata", cpu_rdata, mem_rdata);
      chk("done", {31'b0, dma_done}, {31'b0, m_done});
      chk("dma_rdata", dma_rdata, m_rdata);
   endtask

   // advance the model across the coming rising edge, using the inputs that edge will sample
   task automatic model_update();
      model_eval();
      m_done = m_gnt;
      if (m_gnt) m_rdata = mem_rdata;
      denied = (m_gnt || !dma_req) ? 0 : (denied < LIM ? denied + 1 : LIM);
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] mrd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = ~ca;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = da ^ 32'h5A5A_0000;
      mem_rdata = mrd;
   endtask

   typedef struct {
      logic        cr, cw, dr, dw;
      logic [31:0] da, mrd;
      logic        gnt, stall, we, done;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[20];

   task automatic setv(input int i, input logic cr, input logic cw, input logic dr,
                       input logic dw, input logic [31:0] da, input logic gnt,
                       input logic stall, input logic we, input logic done,
                       input logic [31:0] rd);
      tbl[i].cr = cr; tbl[i].cw = cw; tbl[i].dr = dr; tbl[i].dw = dw; tbl[i].da = da;
      tbl[i].mrd = (i == 0) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
      tbl[i].gnt = gnt; tbl[i].stall = stall; tbl[i].we = we; tbl[i].done = done;
      tbl[i].rd = rd;
   endtask

   initial begin
      logic        cr, cw, dr, dw, hold_dma, hold_cpu;
      logic [31:0] ca, da;
      //     i  cr cw dr dw addr   gnt stl we dn rdata
      setv(0,  0, 0, 1, 0, 32'h10, 1, 0, 0, 0, 32'h0);          // idle bus, DMA read
      setv(1,  0, 0, 0, 0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF);
      setv(2,  1, 1, 1, 0, 32'h10, 0, 0, 1, 0, 32'hDEAD_BEEF);  // CPU store conflict
      setv(3,  1, 1, 1, 0, 32'h10, 0, 0, 1, 0, 32'hDEAD_BEEF);
      setv(4,  0, 0, 1, 0, 32'h10, 1, 0, 0, 0, 32'hDEAD_BEEF);
      setv(5,  1, 0, 1, 1, 32'h20, 0, 0, 0, 1, 32'hA000_0004);  // starvation
      setv(6,  1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0004);
      setv(7,  1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0004);
      setv(8,  1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0004);
      setv(9,  1, 0, 1, 1, 32'h20, 1, 1, 1, 0, 32'hA000_0004);
      setv(10, 1, 0, 1, 1, 32'h20, 0, 0, 0, 1, 32'hA000_0009);
      setv(11, 1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0009);
      setv(12, 1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0009);
      setv(13, 1, 0, 1, 1, 32'h20, 0, 0, 0, 0, 32'hA000_0009);
      setv(14, 1, 0, 1, 1, 32'h20, 1, 1, 1, 0, 32'hA000_0009);
      setv(15, 0, 0, 1, 1, 32'h0,  1, 0, 1, 1, 32'hA000_000E);  // back-to-back writes
      setv(16, 0, 0, 1, 1, 32'h4,  1, 0, 1, 1, 32'hA000_000F);
      setv(17, 0, 0, 1, 1, 32'h8,  1, 0, 1, 1, 32'hA000_0010);
      setv(18, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1, 32'hA000_0011);  // no requests
      setv(19, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'hA000_0011);

      drive(1, 1, 32'h1234, 1, 1, 32'h40, 32'h1111_2222);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", {31'b0, dma_done}, 32'h0);
      chk("rst_rdata", dma_rdata, 32'h0);
      chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
      chk("rst_gnt", {31'b0, dma_gnt}, 32'h0);
      drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         drive(tbl[i].cr, tbl[i].cw, 32'h8000_0000 | 32'(i), tbl[i].dr, tbl[i].dw, tbl[i].da,
               tbl[i].mrd);
         @(negedge clk);
         chk($sformatf("t%0d_gnt", i), {31'b0, dma_gnt}, {31'b0, tbl[i].gnt});
         chk($sformatf("t%0d_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].stall});
         chk($sformatf("t%0d_we", i), {31'b0, mem_we}, {31'b0, tbl[i].we});
         chk($sformatf("t%0d_done", i), {31'b0, dma_done}, {31'b0, tbl[i].done});
         chk($sformatf("t%0d_rdata", i), dma_rdata, tbl[i].rd);
         chk($sformatf("t%0d_addr", i), mem_addr,
             tbl[i].gnt ? tbl[i].da : (32'h8000_0000 | 32'(i)));
         model_update();
      end

      // async reset while three cycles into a conflict
      @(posedge clk); #1 drive(0, 0, 32'h0, 1, 0, 32'h44, 32'h55AA_55AA);
      @(negedge clk); model_check(); model_update();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1 drive(1, 1, 32'hC0 + 32'(k), 1, 0, 32'h48, 32'h0);
         @(negedge clk); model_check(); model_update();
      end
      #2 reset = 1'b0;
      #1;
      chk("arst_done", {31'b0, dma_done}, 32'h0);
      chk("arst_rdata", dma_rdata, 32'h0);
      chk("arst_stall", {31'b0, cpu_stall}, 32'h0);
      denied = 0; m_done = 1'b0; m_rdata = '0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_check(); model_update();
      for (int k = 1; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("arst_force%0d", k), {31'b0, cpu_stall}, {31'b0, k == 4});
         model_check(); model_update();
      end

      // random traffic obeying both masters' hold rules
      hold_dma = 1'b0; hold_cpu = 1'b0;
      cr = 0; cw = 0; dr = 0; dw = 0; ca = 0; da = 0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #1;
         if (!hold_cpu) begin
            cr = ($urandom_range(9) < 7); cw = $urandom_range(1) == 1; ca = $urandom;
         end
         if (!hold_dma) begin
            dr = ($urandom_range(9) < 5); dw = $urandom_range(1) == 1; da = $urandom;
         end
         drive(cr, cw, ca, dr, dw, da, $urandom);
         @(negedge clk);
         model_check();
         model_update();
         hold_cpu = m_frc;
         hold_dma = dr && !m_gnt;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
